// File: rtl/control_sequencer.sv
// Hardwired T0..T7 control sequencer driving CPU datapath strobes; ILLEGAL_TRAP_EN enables the illegal-opcode trap.
// Latency: strobes are Moore-decoded from state, one step per clock. Memory steps hold until mem_ready.
// Backpressure: mem_ready stalls T1/T6/T7 with strobes held; mem_timeout pulses once after MEM_WAIT_MAX idle cycles.
module control_sequencer #(
  parameter int OPW          = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           mem_ready,
  input  logic           stop,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           memRead,
  output logic           memWrite,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           mem_timeout,
  output logic           illegal
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED, S_ILLEGAL
  } state_t;

  state_t        state, state_n, fin;
  logic          started;
  logic [CW-1:0] wait_cnt;
  logic          wait_step;

  logic [OPW-1:0] opcode;
  logic           is_ld, is_ldi, is_st, is_rr, is_imm, is_nop, is_halt, is_defined;
  logic           unused_ir;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  assign is_ld      = (opcode == OPW'(5'b00000));
  assign is_ldi     = (opcode == OPW'(5'b00001));
  assign is_st      = (opcode == OPW'(5'b00010));
  assign is_rr      = (opcode >= OPW'(5'b00011)) && (opcode <= OPW'(5'b01011));
  assign is_imm     = (opcode >= OPW'(5'b01100)) && (opcode <= OPW'(5'b01110));
  assign is_nop     = (opcode == OPW'(5'b11010));
  assign is_halt    = (opcode == OPW'(5'b11011));
  assign is_defined = is_ld | is_ldi | is_st | is_rr | is_imm | is_nop | is_halt;

  // Reset parks in T0 with outputs quiet; the first edge after release arms the sequencer.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_T0;
      started <= 1'b0;
    end else begin
      state   <= state_n;
      started <= 1'b1;
    end
  end

  assign wait_step = started && ((state == S_T1) ||
                                 (state == S_T6 && is_ld) ||
                                 (state == S_T7 && is_st));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
    end else if (state_n != state) begin
      wait_cnt <= '0;
    end else if (wait_step && !mem_ready && wait_cnt != CW'(MEM_WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign mem_timeout = wait_step && !mem_ready && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_n = state;
    fin     = stop ? S_HALTED : S_T0;
    if (started) begin
      case (state)
        S_T0: state_n = S_T1;
        S_T1: state_n = mem_ready ? S_T2 : S_T1;
        S_T2: begin
          if (is_halt)                   state_n = S_HALTED;
          else if (is_nop)               state_n = fin;
          else if (is_defined)           state_n = S_T3;
          else begin
`ifdef ILLEGAL_TRAP_EN
            state_n = S_ILLEGAL;
`else
            state_n = fin;
`endif
          end
        end
        S_T3: state_n = S_T4;
        S_T4: state_n = S_T5;
        S_T5: state_n = (is_ld || is_st) ? S_T6 : fin;
        S_T6: state_n = (is_ld && !mem_ready) ? S_T6 : S_T7;
        S_T7: state_n = (is_st && !mem_ready) ? S_T7 : fin;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    {PCout, MARin, IncPC, memRead, memWrite, MDRin, MDRout, IRin, Yin, Zin,
     Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout} = '0;
    alu_op = '0;
    if (started) begin
      case (state)
        S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
        S_T1: begin memRead = 1'b1; MDRin = 1'b1; end
        S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T3: begin
          Grb = 1'b1;
          Yin = 1'b1;
          if (is_ld || is_ldi || is_st) BAout = 1'b1;
          else                          Rout  = 1'b1;
        end
        S_T4: begin
          Zin = 1'b1;
          if (is_rr) begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            alu_op = opcode;
          end else begin
            // Immediate and address forms reuse the ALU with add/and/or codes.
            Cout = 1'b1;
            if (opcode == OPW'(5'b01101))      alu_op = OPW'(5'b01010);
            else if (opcode == OPW'(5'b01110)) alu_op = OPW'(5'b01011);
            else                               alu_op = OPW'(5'b00011);
          end
        end
        S_T5: begin
          Zlowout = 1'b1;
          if (is_ld || is_st) MARin = 1'b1;
          else begin Gra = 1'b1; Rin = 1'b1; end
        end
        S_T6: begin
          MDRin = 1'b1;
          if (is_ld) memRead = 1'b1;
          else begin Gra = 1'b1; Rout = 1'b1; end
        end
        S_T7: begin
          if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          else       memWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign run = started && (state != S_HALTED) && (state != S_ILLEGAL);

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_ILLEGAL);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the CPU datapath.
- Generates, cycle by cycle, every control strobe the datapath and its select/encode logic consume: PCout, MARin, IncPC, memRead, MDRin/out, IRin, Yin, Zin, Zlowout, Gra/Grb/Grc, Rin/Rout, BAout, Cout.
- Decodes the opcode in IR and walks the T0..T7 step sequence for the supported instruction classes.
- Replaces the hand-scheduled stimulus currently used for phase-2 datapath checks.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- MEM_WAIT_MAX, 15, number of cycles without mem_ready before mem_timeout pulses.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous active-low reset.
- IR  in  32  instruction register contents from the datapath; opcode = IR[31:27].
- mem_ready  in  1  memory handshake; read data valid, or write accepted, this cycle.
- stop  in  1  request to halt at the next instruction boundary.
- PCout, MARin, IncPC, memRead, memWrite, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  datapath strobes.
- alu_op  out  5  ALU operation select, valid in step T4.
- run  out  1  high while executing.
- mem_timeout  out  1  one-cycle pulse on a memory wait overrun.
- illegal  out  1  see Optional Feature.

Behaviour:
- State register and wait counter reset asynchronously when clear=0. State goes to T0, all outputs go to 0, and run goes to 1 on the first clock edge after release.
- Outputs are Moore-decoded from state; IR is used only after T2.
- Opcodes:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, shr=00101, shra=00110, shl=00111, ror=01000, rol=01001, and=01010, or=01011
  - addi=01100, andi=01101, ori=01110
  - nop=11010, halt=11011
- Fetch, all classes:
  - T0: PCout, MARin, IncPC.
  - T1: memRead, MDRin. Hold T1 until mem_ready=1.
  - T2: MDRout, IRin.
- Register-register ALU (add..or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
  - Total 6 cycles with no memory wait.
- Immediate ALU:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op = add / and / or code for addi / andi / ori.
  - T5: Zlowout, Gra, Rin.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin.
- ld:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: memRead, MDRin; wait on mem_ready.
  - T7: MDRout, Gra, Rin.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (memRead=0).
  - T7: memWrite; wait on mem_ready.
- Step ends:
  - nop: return to T0 after T2.
  - halt: enter HALTED after T2.
- HALTED: all strobes 0, run=0. Only clear exits.
- stop:
  - Sampled in the last step of each instruction.
  - If 1, enter HALTED instead of T0.
  - stop during fetch takes effect at the end of that instruction.
- Memory wait:
  - Counter clears on entry to T1, T6 (ld) or T7 (st).
  - While waiting, the step's strobes stay asserted.
  - When the counter reaches MEM_WAIT_MAX with mem_ready still 0, mem_timeout pulses once. The FSM keeps waiting; the counter saturates.
- mem_ready=1 on the cycle a waiting step is entered completes that step in one cycle.
- alu_op is 0 outside T4.
- clear low mid-instruction aborts immediately to reset state.
- Undefined opcodes behave as nop unless ILLEGAL_TRAP_EN is defined.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode after T2 enters state ILLEGAL.
  - illegal=1, run=0, all strobes 0.
  - Held until clear.
- Undefined:
  - Undefined opcodes execute as nop.
  - illegal is tied 0.

Test Plan:
- Reset then IR=0x5091_8000 (and R1,R2,R3), mem_ready=1:
  - T0: PCout, MARin, IncPC. T1: memRead, MDRin. T2: MDRout, IRin.
  - T3: Grb, Rout, Yin. T4: Grc, Rout, Zin, alu_op=01010. T5: Zlowout, Gra, Rin.
  - Next cycle is T0. 6 cycles total.
- ld (IR=0x0080_0005), mem_ready low for 3 cycles in T6:
  - T6 strobes held for 4 cycles, then T7 MDRout, Gra, Rin.
  - Total 11 cycles.
- st (IR=0x1100_0010), mem_ready low for 20 cycles in T7:
  - memWrite held throughout.
  - mem_timeout pulses exactly once, at cycle 15 of the wait.
  - Completes when mem_ready rises.
- halt (IR=0xD800_0000): after T2, run=0, all strobes 0 for 10 cycles. clear low then high restarts at T0.
- stop raised during T1 of an add: add completes through T5, then HALTED; no T0 follows.
- Undefined opcode 11111 with ILLEGAL_TRAP_EN: illegal=1 after T2. Without the macro: returns to T0 with illegal=0. Then clear low during T4 forces all outputs to 0 asynchronously.
